// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: FSM state encodings,
// the default timeout and a small alignment helper.
package load_store_unit_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQUEST = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_ERROR   = 2'd3;

    localparam int DEFAULT_TIMEOUT = 16;

    // Word accesses only: the two low address bits must be zero.
    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/load_store_unit_timeout_counter.sv
// Cycle counter for the REQUEST phase. Cleared outside REQUEST, counts
// while enabled and saturates at TIMEOUT-1, which it flags as terminal.
module lsu_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise step until the terminal value.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != TC_VAL)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the data-memory req/ack interface. Turns a held
// MemRead/MemWrite into one registered bus transaction, stalls the CPU
// until it completes, times out or is rejected, and returns load data.
//
// Handshake: mem_req rises with mem_we/mem_addr/mem_wdata and all four are
// held stable while in REQUEST; the responder completes the access with a
// single-cycle mem_ack (mem_rdata valid in that cycle). mem_req drops on the
// edge that samples mem_ack. mem_ack outside REQUEST is ignored.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int N       = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic [N-1:0] Address,
    input  logic [N-1:0] WriteData,
    output logic [N-1:0] ReadData,
    output logic         Stall,
    output logic         BusError,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic [1:0]   dbg_state_o
);

    logic [1:0]   state_q,     state_d;
    logic         mem_req_q,   mem_req_d;
    logic         mem_we_q,    mem_we_d;
    logic [N-1:0] mem_addr_q,  mem_addr_d;
    logic [N-1:0] mem_wdata_q, mem_wdata_d;
    logic [N-1:0] rdata_q,     rdata_d;
    logic         bus_err_q,   bus_err_d;

    logic cnt_clear;
    logic cnt_en;
    logic cnt_tc;

    lsu_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i    (clock),
        .rst_i    (reset),
        .clear_i  (cnt_clear),
        .enable_i (cnt_en),
        .tc_o     (cnt_tc)
    );

    // FSM next state and next values of every bus/result register.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        bus_err_d   = 1'b0;
        cnt_clear   = 1'b1;
        cnt_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemRead && MemWrite) begin
                    state_d   = ST_ERROR;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end else if (MemRead || MemWrite) begin
                    if (!word_aligned(Address[1:0])) begin
                        // Rejected without touching the bus.
                        state_d   = ST_ERROR;
                        bus_err_d = 1'b1;
                        if (MemRead) rdata_d = '0;
                    end else begin
                        state_d     = ST_REQUEST;
                        mem_req_d   = 1'b1;
                        mem_we_d    = MemWrite;
                        mem_addr_d  = Address;
                        mem_wdata_d = MemWrite ? WriteData : '0;
                    end
                end
            end
            ST_REQUEST: begin
                cnt_clear = 1'b0;
                // An ack on the terminal cycle still completes the access.
                if (mem_ack) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) rdata_d = mem_rdata;
                end else if (cnt_tc) begin
                    state_d   = ST_ERROR;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (!mem_we_q) rdata_d = '0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and output registers, all cleared immediately on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Stall drops in DONE/ERROR, giving exactly one release cycle.
    assign Stall = (MemRead || MemWrite) &&
                   ((state_q == ST_IDLE) || (state_q == ST_REQUEST));

    assign ReadData    = rdata_q;
    assign BusError    = bus_err_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Sits between the CPU datapath (MemRead/MemWrite/ALU address/rt data) and a multicycle data memory responder that uses a req/ack handshake.
- Converts single-cycle load/store intent into a registered bus transaction.
- Stalls the PC until the transaction completes, times out, or is rejected.
- Returns load data and flags bus errors.

Parameters:
- TIMEOUT, 16: max cycles in REQUEST without mem_ack before abort; must be ≥2.
- N, 32: data/address width.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- MemRead  input  1  CPU load request, held until Stall drops.
- MemWrite  input  1  CPU store request, held until Stall drops.
- Address  input  N  byte address from ALU.
- WriteData  input  N  store data.
- ReadData  output  N  registered load result.
- Stall  output  1  combinational; hold PC/pipeline while 1.
- BusError  output  1  one-cycle pulse on rejected or timed-out access.
- mem_req  output  1  request to memory, registered.
- mem_we  output  1  1 = write, 0 = read, registered.
- mem_addr  output  N  registered address.
- mem_wdata  output  N  registered write data.
- mem_rdata  input  N  read data from memory, valid with mem_ack.
- mem_ack  input  1  one-cycle completion strobe from memory.

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0. mem_req, mem_we, BusError=0; mem_addr, mem_wdata, ReadData=0.
- States: IDLE, REQUEST, DONE, ERROR.
- Stall = (MemRead|MemWrite) && state∈{IDLE,REQUEST}. It is 0 in DONE and ERROR, so exactly one release cycle follows each access.
- IDLE:
  - MemRead and MemWrite both 1 → ERROR.
  - Exactly one of them 1 and Address[1:0]≠0 → ERROR; no bus request issued.
  - Exactly one of them 1 and aligned → REQUEST. On the same edge: mem_req=1, mem_we=MemWrite, mem_addr=Address, mem_wdata=WriteData (0 for reads), counter=0.
  - Neither → stay IDLE.
- REQUEST: mem_req, mem_we, mem_addr, mem_wdata held stable; CPU inputs ignored.
  - mem_ack=1 → DONE, mem_req=0. For a read, ReadData=mem_rdata; for a write, ReadData unchanged.
  - Else if counter==TIMEOUT-1 → ERROR, mem_req=0.
  - Else counter+1.
  - mem_ack on the timeout cycle: ack wins, go DONE.
- DONE: one cycle, then IDLE. mem_req stays 0.
- ERROR: BusError=1 for this cycle only; ReadData=0 if the access was a read; then IDLE.
- mem_ack outside REQUEST: ignored, no state change.
- Latency with ack in the first REQUEST cycle: Stall high 2 cycles (IDLE, REQUEST), ReadData valid from the DONE cycle onward. General case: stall cycles = 1 + ack latency.
- Timeout with no ack: Stall high 1+TIMEOUT cycles, then the ERROR cycle.
- ReadData holds its last value until the next completed read or read error.
- Reset during REQUEST: mem_req drops immediately and the transaction is abandoned. A late mem_ack after reset is ignored per the rule above.
- Counter width: $clog2(TIMEOUT) bits; no wrap-around, since it never exceeds TIMEOUT-1.

Decomposition:
- Shared constants header gets: state encodings (IDLE=2'd0, REQUEST=2'd1, DONE=2'd2, ERROR=2'd3) and the default TIMEOUT.
- One natural sub-module: lsu_timeout_counter, with clear, enable, and a terminal-count output at TIMEOUT-1.
- The FSM and output registers stay in load_store_unit.

Test Plan:
- Read, fast responder: MemRead=1, Address=0x100; ack the cycle after mem_req rises with mem_rdata=0xDEADBEEF → mem_req=1/mem_we=0/mem_addr=0x100 for 1 cycle; Stall high 2 cycles; ReadData=0xDEADBEEF in DONE; BusError never set.
- Write, slow responder: MemWrite=1, Address=0x204, WriteData=0x12345678; ack after 5 REQUEST cycles → mem_we=1, mem_wdata=0x12345678 stable throughout; Stall high 6 cycles; ReadData unchanged.
- Timeout: TIMEOUT=4, MemRead=1, Address=0x8, no ack → mem_req high 4 cycles, then ERROR; BusError pulses 1 cycle; ReadData=0; Stall low in the ERROR cycle; next state IDLE.
- Rejects: MemRead=MemWrite=1 (aligned), and separately MemRead=1 with Address=0x102 → mem_req never asserted; BusError pulse on the next cycle; Stall high for exactly 1 cycle.
- Reset mid-REQUEST: assert reset 2 cycles into a read, asynchronously off-edge → mem_req=0 immediately, all outputs reset. A mem_ack arriving after reset release is ignored, and state stays IDLE with MemRead=0.
- Ack on the timeout cycle plus stray ack: TIMEOUT=4, ack in the 4th REQUEST cycle → DONE, not ERROR. A stray ack while in IDLE causes no change.
